// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory arbiter.
// Holds the FSM state encoding, the default bus timeout and the latched request record.
// Imported by mem_arbiter and mem_wait_cnt; carries no logic of its own.
package mem_arbiter_pkg;

  // Default maximum number of bus cycles spent waiting for bus_ack (legal range 1..255).
  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

  // The wait counter must be able to hold TIMEOUT-1, which is at most 254.
  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_I_BUS  = 3'd1,
    ST_D_BUS  = 3'd2,
    ST_I_DONE = 3'd3,
    ST_D_DONE = 3'd4
  } arb_state_t;

  // Request fields captured at grant time; these drive the shared bus.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  function automatic logic is_bus_state(input arb_state_t s);
    return (s == ST_I_BUS) || (s == ST_D_BUS);
  endfunction

endpackage

// File: rtl/mem_arbiter_wait_cnt.sv
// mem_wait_cnt: counts bus cycles spent waiting for an acknowledge.
// Latency: count updates on the rising edge after clr/inc; clr has priority over inc.
// Backpressure: none; the owning FSM leaves the bus state before the counter can wrap.
// Ports: clk, rst_n (async active-low), clr (hold at zero), inc (count one cycle), cnt (current value).
module mem_wait_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned W = WAIT_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between instruction fetch and load/store, data first.
// Latency: minimum 3 cycles per transaction (IDLE grant, BUS with ack, DONE); results valid in DONE.
// Backpressure: if_stall/d_stall hold the requester until its DONE cycle; a silent bus times out.
// Ports:
//   clk, rst_n                           clock and asynchronous active-low reset
//   if_req/if_addr -> if_rdata/if_stall  instruction fetch port
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_stall  load/store port
//   bus_cs/bus_we/bus_addr/bus_wdata, bus_rdata/bus_ack  shared memory bus
//   bus_err                              one-cycle pulse when a transaction times out
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic        bus_cs,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  // Counter value seen in the last permitted wait cycle: TIMEOUT bus cycles in total.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

  arb_state_t              state;
  arb_state_t              state_nxt;
  bus_req_t                req_q;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic                    in_bus;
  logic                    grant_d;
  logic                    grant_i;
  logic                    capture;
  logic                    timeout;

  assign in_bus = is_bus_state(state);

  // Held at zero outside the bus states, so it is always clear on entry to *_BUS.
  mem_wait_cnt #(
    .W (WAIT_CNT_W)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!in_bus),
    .inc   (in_bus && !bus_ack),
    .cnt   (wait_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (d_req) begin
          state_nxt = ST_D_BUS;
          grant_d   = 1'b1;
        end else if (if_req) begin
          state_nxt = ST_I_BUS;
          grant_i   = 1'b1;
        end
      end
      ST_I_BUS: begin
        if (bus_ack) begin
          state_nxt = ST_I_DONE;
          capture   = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_I_DONE;
          timeout   = 1'b1;
        end
      end
      ST_D_BUS: begin
        if (bus_ack) begin
          state_nxt = ST_D_DONE;
          capture   = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_D_DONE;
          timeout   = 1'b1;
        end
      end
      ST_I_DONE: state_nxt = ST_IDLE;
      ST_D_DONE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request fields are only written at grant time, so they stay frozen while bus_cs=1.
  // A flushed transaction still updates its rdata register; the requester has
  // already moved on and simply never looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      bus_err  <= 1'b0;
    end else begin
      bus_err <= timeout;

      if (grant_d) begin
        req_q <= '{we: d_we, addr: d_addr, wdata: d_wdata};
      end else if (grant_i) begin
        req_q <= '{we: 1'b0, addr: if_addr, wdata: 32'h0};
      end

      if (state == ST_I_BUS) begin
        if (timeout) begin
          if_rdata <= '0;
        end else if (capture && !req_q.we) begin
          if_rdata <= bus_rdata;
        end
      end

      if (state == ST_D_BUS) begin
        if (timeout) begin
          d_rdata <= '0;
        end else if (capture && !req_q.we) begin
          d_rdata <= bus_rdata;
        end
      end
    end
  end

  assign bus_cs    = in_bus;
  assign bus_we    = req_q.we;
  assign bus_addr  = req_q.addr;
  assign bus_wdata = req_q.wdata;

  assign if_stall = if_req && (state != ST_I_DONE);
  assign d_stall  = d_req && (state != ST_D_DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (TIMEOUT=4); the bench plays the memory and both requesters.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        bus_cs;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_stall  (if_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_stall   (d_stall),
    .bus_cs    (bus_cs),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 2 time units past it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
    tick(); tick();
    n_tests++; if (bus_cs !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b want 0", bus_cs); end
    n_tests++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus_we); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus_err); end
    n_tests++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus_addr); end
    n_tests++; if (bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus_wdata); end
    n_tests++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_if_rdata: got %h want 0", if_rdata); end
    n_tests++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
    n_tests++; if (if_stall !== 1'b0 || d_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b%b want 00", if_stall, d_stall); end
    rst_n = 1'b1;
  endtask

  // Fetch granted on the first edge after reset release; ack one cycle after cs.
  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    #1;
    n_tests++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_idle: got %b want 1", if_stall); end
    tick();
    n_tests++; if (bus_cs !== 1'b1) begin n_fail++; $display("FAIL fetch_first_grant_cs: got %b want 1", bus_cs); end
    n_tests++; if (bus_addr !== 32'h40 || bus_we !== 1'b0) begin n_fail++; $display("FAIL fetch_addr_we: got %h/%b want 00000040/0", bus_addr, bus_we); end
    n_tests++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_bus1: got %b want 1", if_stall); end
    tick();
    n_tests++; if (bus_cs !== 1'b1 || if_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_bus2: got cs=%b stall=%b want 1/1", bus_cs, if_stall); end
    bus_ack = 1'b1; bus_rdata = 32'h2008_0005;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    n_tests++; if (if_rdata !== 32'h2008_0005) begin n_fail++; $display("FAIL fetch_rdata: got %h want 20080005", if_rdata); end
    n_tests++; if (if_stall !== 1'b0 || bus_cs !== 1'b0) begin n_fail++; $display("FAIL fetch_done: got stall=%b cs=%b want 0/0", if_stall, bus_cs); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL fetch_err: got %b want 0", bus_err); end
    if_req = 1'b0;
    tick();
  endtask

  // Store and fetch arrive together: store goes first, fetch waits with if_stall high.
  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h0000_0080;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (if_stall !== 1'b1 || d_stall !== 1'b1) begin n_fail++; $display("FAIL prio_stall_idle: got %b%b want 11", if_stall, d_stall); end
    tick();
    n_tests++; if (bus_cs !== 1'b1 || bus_we !== 1'b1) begin n_fail++; $display("FAIL prio_write_cs_we: got %b/%b want 1/1", bus_cs, bus_we); end
    n_tests++; if (bus_addr !== 32'h100 || bus_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL prio_write_fields: got %h/%h want 00000100/deadbeef", bus_addr, bus_wdata); end
    d_addr = 32'h0000_0999; d_wdata = 32'h0; d_we = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    #1;
    n_tests++; if (bus_addr !== 32'h100 || bus_wdata !== 32'hDEAD_BEEF || bus_we !== 1'b1) begin n_fail++; $display("FAIL prio_latched: got %h/%h/%b want 00000100/deadbeef/1", bus_addr, bus_wdata, bus_we); end
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    n_tests++; if (d_stall !== 1'b0 || if_stall !== 1'b1) begin n_fail++; $display("FAIL prio_d_done: got d=%b i=%b want 0/1", d_stall, if_stall); end
    n_tests++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL prio_write_no_rdata: got %h want 0", d_rdata); end
    d_req = 1'b0;
    tick();
    n_tests++; if (if_stall !== 1'b1 || bus_cs !== 1'b0) begin n_fail++; $display("FAIL prio_idle: got stall=%b cs=%b want 1/0", if_stall, bus_cs); end
    tick();
    n_tests++; if (bus_cs !== 1'b1 || bus_addr !== 32'h80 || bus_we !== 1'b0) begin n_fail++; $display("FAIL prio_fetch_grant: got %b/%h/%b want 1/00000080/0", bus_cs, bus_addr, bus_we); end
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    n_tests++; if (if_rdata !== 32'hCAFE_F00D || if_stall !== 1'b0) begin n_fail++; $display("FAIL prio_fetch_done: got %h/%b want cafef00d/0", if_rdata, if_stall); end
    if_req = 1'b0;
    tick();
  endtask

  // Minimum 3-cycle load: ack in the first bus cycle.
  task automatic test_load();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h55AA_1234;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    n_tests++; if (d_rdata !== 32'h55AA_1234 || d_stall !== 1'b0) begin n_fail++; $display("FAIL load_done: got %h/%b want 55aa1234/0", d_rdata, d_stall); end
    d_req = 1'b0;
    tick();
    n_tests++; if (bus_cs !== 1'b0) begin n_fail++; $display("FAIL load_idle_cs: got %b want 0", bus_cs); end
  endtask

  task automatic test_timeout();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (bus_cs !== 1'b1 || bus_err !== 1'b0 || d_stall !== 1'b1) begin n_fail++; $display("FAIL timeout_wait%0d: got cs=%b err=%b stall=%b want 1/0/1", i, bus_cs, bus_err, d_stall); end
    end
    tick();
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", bus_err); end
    n_tests++; if (d_rdata !== 32'h0 || d_stall !== 1'b0 || bus_cs !== 1'b0) begin n_fail++; $display("FAIL timeout_done: got %h/%b/%b want 0/0/0", d_rdata, d_stall, bus_cs); end
    d_req = 1'b0;
    tick();
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_width: got %b want 0", bus_err); end
  endtask

  task automatic test_spurious_ack();
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    n_tests++; if (bus_cs !== 1'b0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL spurious_state: got cs=%b err=%b want 0/0", bus_cs, bus_err); end
    n_tests++; if (if_rdata !== 32'hCAFE_F00D || d_rdata !== 32'h0) begin n_fail++; $display("FAIL spurious_rdata: got %h/%h want cafef00d/00000000", if_rdata, d_rdata); end
    bus_ack = 1'b0; bus_rdata = 32'h0;
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h0000_0044;
    tick();
    if_req = 1'b0;
    #1;
    n_tests++; if (if_stall !== 1'b0 || bus_cs !== 1'b1) begin n_fail++; $display("FAIL flush_drop: got stall=%b cs=%b want 0/1", if_stall, bus_cs); end
    tick();
    n_tests++; if (bus_cs !== 1'b1 || bus_addr !== 32'h44) begin n_fail++; $display("FAIL flush_still_bus: got %b/%h want 1/00000044", bus_cs, bus_addr); end
    bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    n_tests++; if (bus_cs !== 1'b0 || if_stall !== 1'b0) begin n_fail++; $display("FAIL flush_done: got cs=%b stall=%b want 0/0", bus_cs, if_stall); end
    tick(); tick();
    n_tests++; if (bus_cs !== 1'b0) begin n_fail++; $display("FAIL flush_no_regrant: got %b want 0", bus_cs); end
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
    tick();
    n_tests++; if (bus_cs !== 1'b1) begin n_fail++; $display("FAIL rstmid_bus: got %b want 1", bus_cs); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus_cs !== 1'b0 || bus_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_cs: got %b/%h want 0/0", bus_cs, bus_addr); end
    n_tests++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %h/%h want 0/0", if_rdata, d_rdata); end
    n_tests++; if (d_stall !== 1'b1) begin n_fail++; $display("FAIL rstmid_stall: got %b want 1", d_stall); end
    d_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_tests++; if (bus_cs !== 1'b0 || bus_err !== 1'b0 || d_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: got %b/%b/%b want 0/0/0", bus_cs, bus_err, d_stall); end
    d_req = 1'b1; d_addr = 32'h0000_0500;
    tick();
    n_tests++; if (bus_cs !== 1'b1 || bus_addr !== 32'h500) begin n_fail++; $display("FAIL rstmid_regrant: got %b/%h want 1/00000500", bus_cs, bus_addr); end
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    n_tests++; if (d_rdata !== 32'h0BAD_F00D || d_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_load: got %h/%b want 0badf00d/0", d_rdata, d_stall); end
    d_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_load();
    test_timeout();
    test_spurious_ack();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255; maximum bus wait cycles before a transaction is abandoned; range 1..255.
REQ-002 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: if_req  input  1  instruction fetch request, held until done.
REQ-005 SHALL have ports: if_addr  input  32  fetch byte address.
REQ-006 SHALL have ports: if_rdata  output  32  fetched word, valid in the if_done cycle.
REQ-007 SHALL have ports: if_stall  output  1  freeze IF/ID (feeds controller rom_stall).
REQ-008 SHALL have ports: d_req  input  1  load/store request; d_we  input  1  store; d_addr  input  32; d_wdata  input  32.
REQ-009 SHALL have ports: d_rdata  output  32  load data, valid in the d_done cycle; d_stall  output  1  (feeds ram_stall).
REQ-010 SHALL have ports: bus_cs  output  1; bus_we  output  1; bus_addr  output  32; bus_wdata  output  32; bus_rdata  input  32; bus_ack  input  1  single shared memory.
REQ-011 SHALL have ports: bus_err  output  1  one-cycle pulse on timeout.

Function
REQ-012 SHALL implement FSM states IDLE, I_BUS, D_BUS, I_DONE, D_DONE.
REQ-013 IDLE: d_req=1 -> D_BUS (data has fixed priority); else if_req=1 -> I_BUS; else stay.
REQ-014 On leaving IDLE, SHALL latch addr/we/wdata of the granted port into registers driving bus_addr/bus_we/bus_wdata; bus_cs=1 throughout *_BUS, 0 elsewhere.
REQ-015 In *_BUS, bus_ack=1 SHALL capture bus_rdata into that port's rdata register and go to matching *_DONE; bus_we ignores rdata (register keeps old value).
REQ-016 A wait counter SHALL clear on entering *_BUS and increment each cycle without ack; reaching TIMEOUT SHALL pulse bus_err, load rdata with 0, go to *_DONE.
REQ-017 *_DONE lasts exactly one cycle, then IDLE; minimum transaction = IDLE, BUS (ack same cycle), DONE = 3 cycles.
REQ-018 if_stall = if_req AND NOT (state==I_DONE); d_stall = d_req AND NOT (state==D_DONE); combinational.
REQ-019 Request deasserted mid-transaction (flush): bus transaction SHALL still complete; result discarded, no stall effect.
REQ-020 Both requests pending: data served first; IF served in the following IDLE if still requesting; if_stall stays 1 throughout.
REQ-021 bus_ack outside *_BUS SHALL be ignored.
REQ-022 Latched request fields SHALL not change while bus_cs=1, even if port inputs change.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, counter 0, bus_cs/bus_we/bus_err 0, bus_addr/bus_wdata/if_rdata/d_rdata 0.
REQ-024 Reset mid-transaction SHALL drop bus_cs immediately; no done pulse after release.
REQ-025 First grant possible on first rising edge after rst_n deasserts.

Structure
REQ-026 State encoding and TIMEOUT default SHALL live in the shared define header beside the pipeline constants.
REQ-027 Single module; no sub-module except an optional wait_counter (mem_wait_cnt).

Verification
REQ-028 if_req=1, if_addr=0x0000_0040, ack 1 cycle after cs, rdata=0x2008_0005 -> if_stall 1 for 3 cycles, if_rdata=0x2008_0005 in I_DONE, if_stall 0.
REQ-029 if_req and d_req (store, addr 0x100, wdata 0xDEAD_BEEF) same cycle -> bus write 0x100/0xDEAD_BEEF first, then fetch; if_stall until I_DONE.
REQ-030 Load with bus_ack never asserted, TIMEOUT=4 -> bus_err pulse after 4 BUS cycles, d_rdata=0, d_stall drops in D_DONE.
REQ-031 if_req dropped during I_BUS -> transaction completes, if_stall 0 immediately, next IDLE grants nothing.
REQ-032 rst_n low during D_BUS -> bus_cs 0 same cycle, state IDLE, outputs zero; after release, new d_req served normally.
REQ-033 Spurious bus_ack in IDLE -> no state change, rdata unchanged.
